// File: rtl/reset_pkg.sv
// Shared definitions for the video-pipeline reset sequencer: FSM state
// encodings, reset-cause codes and a counter-width helper.
package reset_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STRETCH   = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam logic [1:0] RST_CAUSE_EXT  = 2'b00;
  localparam logic [1:0] RST_CAUSE_LOCK = 2'b01;
  localparam logic [1:0] RST_CAUSE_SW   = 2'b10;

  localparam logic [7:0] LOCK_LOST_MAX = 8'hFF;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_ff.sv
// Multi-flop bit synchroniser with asynchronous active-low reset. Used both as
// the async-assert/sync-release chain for ext_reset and as the pll_lock
// synchroniser.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic ext_reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the input through the chain; reset forces every flop to RESET_VAL.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer for the video pipeline: synchronises ext_reset release and
// pll_lock, filters lock, stretches, then releases NUM_STAGES active-low
// domain resets in order. Lock loss or a software request re-enters reset.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYCLES = 15,
  parameter int STAGE_GAP   = 16
) (
  input  logic                  clk,
  input  logic                  ext_reset,
  input  logic                  pll_lock,
  input  logic                  sw_reset_req,
  output logic [NUM_STAGES-1:0] resetn_out,
  output logic                  all_ready,
  output logic [1:0]            rst_cause,
  output logic [7:0]            lock_lost_cnt
);

  localparam int LOCK_W = cnt_width(LOCK_FILTER);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int GAP_W  = cnt_width(STAGE_GAP);
  localparam int IDX_W  = cnt_width(NUM_STAGES);

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FILTER - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  logic                  w_rst_sync;
  logic                  w_lock_s;
  logic [NUM_STAGES-1:0] w_stage_bit;

  state_t                r_state;
  logic [LOCK_W-1:0]     r_lock_cnt;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_STAGES-1:0] r_resetn;
  logic                  r_all_ready;
  logic [1:0]            r_cause;
  logic [7:0]            r_lost_cnt;

  // Reset release chain: asserts with ext_reset, releases after SYNC_STAGES edges.
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_rst_sync (
    .clk       (clk),
    .ext_reset (ext_reset),
    .i_d       (1'b1),
    .o_q       (w_rst_sync)
  );

  // pll_lock comes from the PLL's own timing; bring it into clk.
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_lock_sync (
    .clk       (clk),
    .ext_reset (ext_reset),
    .i_d       (pll_lock),
    .o_q       (w_lock_s)
  );

  assign w_stage_bit = NUM_STAGES'(1) << r_idx;

  // Sequencer FSM with registered outputs; all counters cleared on every state change.
  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) begin
      r_state     <= ST_WAIT_LOCK;
      r_lock_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_idx       <= '0;
      r_resetn    <= '0;
      r_all_ready <= 1'b0;
      r_cause     <= RST_CAUSE_EXT;
      r_lost_cnt  <= '0;
    end else if (w_rst_sync) begin
      if (r_state == ST_WAIT_LOCK) begin
        if (!w_lock_s) begin
          r_lock_cnt <= '0;
        end else if (r_lock_cnt == LOCK_LAST) begin
          r_lock_cnt <= '0;
          r_hold_cnt <= '0;
          r_state    <= ST_STRETCH;
        end else begin
          r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
        end
      end else if (!w_lock_s) begin
        // Lock loss outranks a simultaneous software request.
        r_resetn    <= '0;
        r_all_ready <= 1'b0;
        r_cause     <= RST_CAUSE_LOCK;
        if (r_lost_cnt != LOCK_LOST_MAX) r_lost_cnt <= r_lost_cnt + 8'd1;
        r_lock_cnt  <= '0;
        r_hold_cnt  <= '0;
        r_gap_cnt   <= '0;
        r_idx       <= '0;
        r_state     <= ST_WAIT_LOCK;
      end else if (sw_reset_req && (r_state == ST_RELEASE || r_state == ST_RUN)) begin
        // Lock is still good, so skip re-filtering and go straight to the stretch.
        r_resetn    <= '0;
        r_all_ready <= 1'b0;
        r_cause     <= RST_CAUSE_SW;
        r_hold_cnt  <= '0;
        r_gap_cnt   <= '0;
        r_idx       <= '0;
        r_state     <= ST_STRETCH;
      end else if (r_state == ST_STRETCH) begin
        if (r_hold_cnt == HOLD_LAST) begin
          r_hold_cnt <= '0;
          r_gap_cnt  <= '0;
          r_idx      <= '0;
          r_state    <= ST_RELEASE;
        end else begin
          r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
      end else if (r_state == ST_RELEASE) begin
        // A stage is released whenever the gap counter is at zero.
        if (r_gap_cnt == '0 && r_idx == IDX_LAST) begin
          r_resetn    <= r_resetn | w_stage_bit;
          r_all_ready <= 1'b1;
          r_state     <= ST_RUN;
        end else begin
          if (r_gap_cnt == '0) r_resetn <= r_resetn | w_stage_bit;
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= '0;
            r_idx     <= r_idx + IDX_W'(1);
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
      end
    end
  end

  assign resetn_out    = r_resetn;
  assign all_ready     = r_all_ready;
  assign rst_cause     = r_cause;
  assign lock_lost_cnt = r_lost_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer. Two instances run side by side:
// defaults, and a swept corner (8 stages, gap 1, filter 1, 3 sync flops).
// Expectations come from a time-based model: once lock has been qualified the
// model records the edge at which stage 0 is due and derives each output bit
// from elapsed edges.
module tb_reset_sequencer;

  localparam int NI = 2;

  logic clk = 1'b0;
  logic ext_reset = 1'b0;
  logic pll_lock = 1'b0;
  logic sw_reset_req = 1'b0;

  logic [2:0] resetn_a;
  logic       ready_a;
  logic [1:0] cause_a;
  logic [7:0] cnt_a;
  logic [7:0] resetn_b;
  logic       ready_b;
  logic [1:0] cause_b;
  logic [7:0] cnt_b;

  int n_cmp = 0;
  int n_fail = 0;

  // Per-instance parameters as seen by the model.
  int p_n [NI] = '{3, 8};
  int p_s [NI] = '{2, 3};
  int p_f [NI] = '{8, 1};
  int p_h [NI] = '{15, 3};
  int p_g [NI] = '{16, 1};

  // Model state.
  int         now = 0;
  int         since_rel [NI];
  int         run [NI];
  int         t0 [NI];
  int         lost [NI];
  bit         armed [NI];
  logic [1:0] cause [NI];
  bit         lk [NI][8];

  always #5 clk = ~clk;

  reset_sequencer dut_a (
    .clk           (clk),
    .ext_reset     (ext_reset),
    .pll_lock      (pll_lock),
    .sw_reset_req  (sw_reset_req),
    .resetn_out    (resetn_a),
    .all_ready     (ready_a),
    .rst_cause     (cause_a),
    .lock_lost_cnt (cnt_a)
  );

  reset_sequencer #(
    .NUM_STAGES (8), .SYNC_STAGES (3), .LOCK_FILTER (1), .HOLD_CYCLES (3), .STAGE_GAP (1)
  ) dut_b (
    .clk           (clk),
    .ext_reset     (ext_reset),
    .pll_lock      (pll_lock),
    .sw_reset_req  (sw_reset_req),
    .resetn_out    (resetn_b),
    .all_ready     (ready_b),
    .rst_cause     (cause_b),
    .lock_lost_cnt (cnt_b)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    since_rel[k] = 0;
    run[k]       = 0;
    t0[k]        = 0;
    lost[k]      = 0;
    armed[k]     = 1'b0;
    cause[k]     = 2'b00;
    for (int j = 0; j < 8; j++) lk[k][j] = 1'b0;
  endtask

  // One rising edge of the model, using the inputs present at that edge.
  task automatic model_edge(input int k);
    bit ls;
    bit rs;
    if (!ext_reset) begin
      model_reset(k);
      return;
    end
    ls = lk[k][p_s[k]-1];
    rs = (since_rel[k] >= p_s[k]);
    if (rs) begin
      if (armed[k]) begin
        if (!ls) begin
          armed[k] = 1'b0;
          run[k]   = 0;
          cause[k] = 2'b01;
          if (lost[k] < 255) lost[k]++;
        end else if (sw_reset_req && now >= t0[k]) begin
          t0[k]    = now + p_h[k] + 1;
          cause[k] = 2'b10;
        end
      end else if (ls) begin
        run[k]++;
        if (run[k] == p_f[k]) begin
          armed[k] = 1'b1;
          run[k]   = 0;
          t0[k]    = now + p_h[k] + 1;
        end
      end else begin
        run[k] = 0;
      end
    end
    for (int j = 7; j > 0; j--) lk[k][j] = lk[k][j-1];
    lk[k][0] = pll_lock;
    if (since_rel[k] < p_s[k]) since_rel[k]++;
  endtask

  function automatic logic [7:0] exp_resetn(input int k);
    logic [7:0] r = '0;
    for (int i = 0; i < p_n[k]; i++)
      if (armed[k] && now >= t0[k] + i * p_g[k]) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] exp_ready(input int k);
    return {7'b0, armed[k] && now >= t0[k] + (p_n[k] - 1) * p_g[k]};
  endfunction

  task automatic check_all();
    check("a_resetn", {5'b0, resetn_a}, exp_resetn(0));
    check("a_ready",  {7'b0, ready_a},  exp_ready(0));
    check("a_cause",  {6'b0, cause_a},  {6'b0, cause[0]});
    check("a_lostcnt", cnt_a,           8'(lost[0]));
    check("b_resetn", resetn_b,         exp_resetn(1));
    check("b_ready",  {7'b0, ready_b},  exp_ready(1));
    check("b_cause",  {6'b0, cause_b},  {6'b0, cause[1]});
    check("b_lostcnt", cnt_b,           8'(lost[1]));
  endtask

  // Advance one edge, update the model, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    now++;
    for (int k = 0; k < NI; k++) model_edge(k);
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Assert ext_reset between edges and confirm outputs clear before any edge.
  task automatic async_reset();
    #2;
    ext_reset = 1'b0;
    for (int k = 0; k < NI; k++) model_reset(k);
    #1;
    check_all();
    ticks(3);
  endtask

  initial begin
    int lock_low_left;
    for (int k = 0; k < NI; k++) model_reset(k);

    // Test 1: lock already present, release ext_reset just after edge 0.
    pll_lock = 1'b1;
    ticks(4);
    check_all();
    ext_reset = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      tick();
      if (e == 7)  check("t1_b_pre",  resetn_b, 8'h00);
      if (e == 8)  check("t1_b_bit0", resetn_b, 8'h01);
      if (e == 15) check("t1_b_all",  {ready_b, resetn_b[6:0]}, 8'hFF);
      if (e == 25) check("t1_a_pre",  {5'b0, resetn_a}, 8'h00);
      if (e == 26) check("t1_a_001",  {5'b0, resetn_a}, 8'h01);
      if (e == 42) check("t1_a_011",  {5'b0, resetn_a}, 8'h03);
      if (e == 57) check("t1_a_rdy0", {7'b0, ready_a},  8'h00);
      if (e == 58) check("t1_a_111",  {4'b0, ready_a, resetn_a}, 8'h0F);
    end

    // Test 2: lock absent at release, arrives at edge 100.
    async_reset();
    pll_lock = 1'b0;
    ext_reset = 1'b1;
    for (int e = 1; e <= 200; e++) begin
      tick();
      if (e == 99) pll_lock = 1'b1;
      if (e == 124) check("t2_a_none", {5'b0, resetn_a}, 8'h00);
      if (e == 127) check("t2_a_bit0", {7'b0, resetn_a[0]}, 8'h01);
    end

    // Test 3: lock dropped for 3 cycles while running.
    pll_lock = 1'b0;
    ticks(3);
    pll_lock = 1'b1;
    ticks(2);
    check("t3_a_cause", {6'b0, cause_a}, 8'h01);
    check("t3_a_cnt", cnt_a, 8'd1);
    ticks(90);

    // Test 4: software request alone, then coincident with lock-synchroniser drop.
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    check("t4_a_cause", {6'b0, cause_a}, 8'h02);
    ticks(80);
    pll_lock = 1'b0;
    ticks(2);
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    check("t4_a_both", {6'b0, cause_a}, 8'h01);
    pll_lock = 1'b1;
    ticks(80);

    // Test 5: ext_reset pulsed mid-RELEASE.
    async_reset();
    ext_reset = 1'b1;
    ticks(35);
    async_reset();
    check("t5_a_cnt0", cnt_a, 8'd0);
    ext_reset = 1'b1;

    // Lock pulse one cycle short of the filter never releases the default instance.
    pll_lock = 1'b0;
    ticks(6);
    pll_lock = 1'b1;
    ticks(7);
    pll_lock = 1'b0;
    ticks(40);
    check("t6_a_short", {5'b0, resetn_a}, 8'h00);

    // Randomised section: lock drops of random length, sw pulses, rare ext_reset.
    pll_lock = 1'b1;
    lock_low_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (lock_low_left > 0) begin
        lock_low_left--;
        pll_lock = (lock_low_left == 0);
      end else if ($urandom_range(149, 0) == 0) begin
        lock_low_left = $urandom_range(12, 1);
        pll_lock = 1'b0;
      end
      sw_reset_req = ($urandom_range(47, 0) == 0);
      if ($urandom_range(999, 0) == 0) begin
        sw_reset_req = 1'b0;
        async_reset();
        ext_reset = 1'b1;
      end
      tick();
    end
    sw_reset_req = 1'b0;
    pll_lock = 1'b1;
    ticks(80);

    // 300 lock-loss events: counter must saturate.
    for (int r = 0; r < 300; r++) begin
      pll_lock = 1'b0;
      ticks(2);
      pll_lock = 1'b1;
      ticks(20);
    end
    check("t5_a_sat", cnt_a, 8'd255);
    check("t5_b_sat", cnt_b, 8'd255);
    async_reset();
    check("t5_a_clr", cnt_a, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
